// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module   : instr_encoder_loader
// Encodes MIPS instruction fields and writes them to sequential imem words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
    parameter int ADDR_W     = 6,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_class,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              finish,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W-1:0] START_PTR = START_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [ADDR_W:0]   count;
    logic [31:0]       encoded;
    logic              legal;

    always_comb begin
        encoded = 32'd0;
        legal   = 1'b1;
        case (op_class)
            3'd0:    encoded = {OP_RTYPE, rs, rt, rd, shamt, funct};
            3'd1:    encoded = {OP_LW, rs, rt, imm};
            3'd2:    encoded = {OP_SW, rs, rt, imm};
            3'd3:    encoded = {OP_ADDI, rs, rt, imm};
            3'd4:    encoded = {OP_BEQ, rs, rt, imm};
            3'd5:    encoded = {OP_J, target};
            default: legal   = 1'b0;
        endcase
    end

    // finish outranks in_valid in IDLE; a finish seen mid-write still lets the write land.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (finish)
                    next_state = S_DONE;
                else if (in_valid && legal)
                    next_state = S_WRITE;
            end
            S_WRITE: begin
                if (ptr == PTR_MAX || finish)
                    next_state = S_DONE;
                else
                    next_state = S_IDLE;
            end
            S_DONE:  next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= START_PTR;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            count   <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && !finish && in_valid) begin
                if (legal)
                    wdata_q <= encoded;
                else
                    err_q <= 1'b1;
            end
            // The last word leaves the pointer parked at the top instead of wrapping.
            if (state == S_WRITE) begin
                count <= count + 1'b1;
                if (ptr != PTR_MAX)
                    ptr <= ptr + 1'b1;
            end
        end
    end

    assign in_ready      = (state == S_IDLE) & ~rst;
    assign imem_we       = (state == S_WRITE);
    assign busy          = (state == S_WRITE);
    assign done          = (state == S_DONE);
    assign imem_addr     = ptr;
    assign imem_wdata    = wdata_q;
    assign err           = err_q;
    assign words_written = count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: default-size instance plus a 4-word instance.
`default_nettype none

module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  op_class;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        finish;

    logic        in_ready, imem_we, busy, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  words_written;

    logic        s_in_ready, s_we, s_busy, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_ww;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(6), .START_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .finish(finish),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .words_written(words_written)
    );

    instr_encoder_loader #(.ADDR_W(2), .START_ADDR(0)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .op_class(op_class), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .finish(finish),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .err(s_err), .words_written(s_ww)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [15:0] im, input logic [25:0] tg);
        op_class = op; rs = a; rt = b; rd = c; shamt = 5'd0; funct = 6'h20;
        imm = im; target = tg;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        finish   = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; finish = 1'b0;
        set_word(3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        #2;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", imem_we); end
        tests++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_flags got done=%b err=%b busy=%b exp 0", done, err, busy); end
        tests++; if (words_written !== 7'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", words_written); end
        tests++; if (imem_addr !== 6'd0 || imem_wdata !== 32'd0) begin fails++; $display("FAIL reset_addr_data got %h/%h exp 0/0", imem_addr, imem_wdata); end
        tick();
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_rtype;
        set_word(3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL rtype_we got we=%b busy=%b exp 1/1", imem_we, busy); end
        tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL rtype_addr got %0d exp 0", imem_addr); end
        tests++; if (imem_wdata !== 32'h00221820) begin fails++; $display("FAIL rtype_wdata got %h exp 00221820", imem_wdata); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rtype_ready_in_write got %b exp 0", in_ready); end
        in_valid = 1'b0;
        tick();
        tests++; if (imem_we !== 1'b0) begin fails++; $display("FAIL rtype_we_pulse got %b exp 0", imem_we); end
        tests++; if (words_written !== 7'd1) begin fails++; $display("FAIL rtype_count got %0d exp 1", words_written); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rtype_ready_after got %b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_w [5];
        exp_w[0] = 32'h8C080004; exp_w[1] = 32'hAC080004; exp_w[2] = 32'h20090005;
        exp_w[3] = 32'h1022FFFF; exp_w[4] = 32'h08000010;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_word(3'd1, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
                1: set_word(3'd2, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
                2: set_word(3'd3, 5'd0, 5'd9, 5'd0, 16'h0005, 26'd0);
                3: set_word(3'd4, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
                default: set_word(3'd5, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
            endcase
            in_valid = 1'b1;
            tick();
            tests++; if (imem_we !== 1'b1 || imem_addr !== 6'(i)) begin fails++; $display("FAIL b2b_write[%0d] got we=%b addr=%0d exp 1/%0d", i, imem_we, imem_addr, i); end
            tests++; if (imem_wdata !== exp_w[i]) begin fails++; $display("FAIL b2b_wdata[%0d] got %h exp %h", i, imem_wdata, exp_w[i]); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp 0", i, in_ready); end
            tick();
            tests++; if (imem_we !== 1'b0 || words_written !== 7'(i + 1)) begin fails++; $display("FAIL b2b_idle[%0d] got we=%b count=%0d exp 0/%0d", i, imem_we, words_written, i + 1); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal;
        do_reset();
        set_word(3'd7, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
        in_valid = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL illegal_drop got we=%b err=%b exp 0/1", imem_we, err); end
        tests++; if (imem_addr !== 6'd0 || words_written !== 7'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL illegal_ptr got addr=%0d count=%0d ready=%b exp 0/0/1", imem_addr, words_written, in_ready); end
        set_word(3'd1, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
        tick();
        tests++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h8C080004) begin fails++; $display("FAIL illegal_next_lw got we=%b addr=%0d data=%h exp 1/0/8c080004", imem_we, imem_addr, imem_wdata); end
        in_valid = 1'b0;
        tick();
        tests++; if (err !== 1'b1 || words_written !== 7'd1) begin fails++; $display("FAIL illegal_sticky got err=%b count=%0d exp 1/1", err, words_written); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_word(3'd3, 5'd0, 5'(i), 5'd0, 16'(i), 26'd0);
            in_valid = 1'b1;
            tick();
            tests++; if (s_we !== 1'b1 || s_addr !== 2'(i)) begin fails++; $display("FAIL full_write[%0d] got we=%b addr=%0d exp 1/%0d", i, s_we, s_addr, i); end
            in_valid = 1'b0;
            tick();
        end
        tests++; if (s_done !== 1'b1 || s_in_ready !== 1'b0) begin fails++; $display("FAIL full_done got done=%b ready=%b exp 1/0", s_done, s_in_ready); end
        tests++; if (s_ww !== 3'd4 || s_we !== 1'b0) begin fails++; $display("FAIL full_count got count=%0d we=%b exp 4/0", s_ww, s_we); end
        in_valid = 1'b1;
        tick();
        tests++; if (s_we !== 1'b0) begin fails++; $display("FAIL full_fifth_a got we=%b exp 0", s_we); end
        tick();
        tests++; if (s_we !== 1'b0 || s_ww !== 3'd4) begin fails++; $display("FAIL full_fifth_b got we=%b count=%0d exp 0/4", s_we, s_ww); end
        in_valid = 1'b0;
    endtask

    task automatic test_finish;
        do_reset();
        set_word(3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        in_valid = 1'b1;
        finish   = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL finish_idle got we=%b done=%b ready=%b exp 0/1/0", imem_we, done, in_ready); end
        finish = 1'b0;
        tick();
        tests++; if (imem_we !== 1'b0 || words_written !== 7'd0 || done !== 1'b1) begin fails++; $display("FAIL finish_idle_hold got we=%b count=%0d done=%b exp 0/0/1", imem_we, words_written, done); end
        in_valid = 1'b0;
        do_reset();
        set_word(3'd1, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
        in_valid = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b1) begin fails++; $display("FAIL finish_write_we got %b exp 1", imem_we); end
        in_valid = 1'b0;
        finish   = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b0 || words_written !== 7'd1 || done !== 1'b1) begin fails++; $display("FAIL finish_write got we=%b count=%0d done=%b exp 0/1/1", imem_we, words_written, done); end
        finish = 1'b0;
    endtask

    task automatic test_rst_mid_write;
        do_reset();
        set_word(3'd5, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        set_word(3'd6, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        in_valid = 1'b1;
        tick();
        set_word(3'd1, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
        tick();
        tests++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || err !== 1'b1) begin fails++; $display("FAIL rstmid_pre got we=%b addr=%0d err=%b exp 1/1/1", imem_we, imem_addr, err); end
        #1 rst = 1'b1;
        #1;
        tests++; if (imem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_we got we=%b busy=%b ready=%b exp 0/0/0", imem_we, busy, in_ready); end
        tests++; if (done !== 1'b0 || err !== 1'b0 || words_written !== 7'd0 || imem_addr !== 6'd0) begin fails++; $display("FAIL rstmid_state got done=%b err=%b count=%0d addr=%0d exp 0/0/0/0", done, err, words_written, imem_addr); end
        in_valid = 1'b0;
        #1 rst = 1'b0;
        set_word(3'd3, 5'd0, 5'd9, 5'd0, 16'h0005, 26'd0);
        in_valid = 1'b1;
        tick();
        tests++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h20090005) begin fails++; $display("FAIL rstmid_after got we=%b addr=%0d data=%h exp 1/0/20090005", imem_we, imem_addr, imem_wdata); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_illegal();
        test_full();
        test_finish();
        test_rst_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
